// File: rtl/frac_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : frac_pkg
//  Brief   : Shared state encoding and Qm.f format constants for the fractal
//            scheduler and its engine array.
//  Rev     : 1.0  initial release
// ============================================================================
package frac_pkg;

  localparam int FRAC_W = 32;
  localparam int FRAC_M = 4;
  localparam int FRAC_F = FRAC_W - FRAC_M;
  localparam int ITER_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } frac_state_t;

endpackage : frac_pkg
`default_nettype wire

// File: rtl/frac_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : frac_rr_pick
//  Brief   : Round-robin picker: first set request at or after ptr (wrapping)
//            -> one-hot grant, binary index and valid.
//  Rev     : 1.0  initial release
// ============================================================================
module frac_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int w_j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    w_j   = 0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!valid && req[w_j]) begin
        valid      = 1'b1;
        grant[w_j] = 1'b1;
        idx        = PW'(w_j);
      end
    end
  end

endmodule : frac_rr_pick
`default_nettype wire

// File: rtl/frac_sched.sv
`default_nettype none
// ============================================================================
//  Module  : frac_sched
//  Brief   : Sweeps an HRES x VRES pixel grid, dispatches c=(cx,cy) to NE
//            shared engines and streams (address, iter) to a frame buffer.
//  Rev     : 1.0  initial release
// ============================================================================
module frac_sched
  import frac_pkg::*;
#(
  parameter int W    = FRAC_W,
  parameter int M    = FRAC_M,
  parameter int NE   = 4,
  parameter int HRES = 640,
  parameter int VRES = 480,
  parameter int AW   = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     cx0,
  input  logic [W-1:0]     cy0,
  input  logic [W-1:0]     dx,
  input  logic [W-1:0]     dy,
  input  logic [15:0]      max_it,
  output logic             busy,
  output logic             done_tick,
  output logic [W-1:0]     eng_cx,
  output logic [W-1:0]     eng_cy,
  output logic [15:0]      eng_max_it,
  output logic [NE-1:0]    eng_start,
  input  logic [NE-1:0]    eng_ready,
  input  logic [NE-1:0]    eng_done,
  input  logic [NE*16-1:0] eng_iter,
  output logic             wr_valid,
  output logic [AW-1:0]    wr_addr,
  output logic [15:0]      wr_data,
  input  logic             wr_ready
);

  localparam int            PW       = (NE > 1) ? $clog2(NE) : 1;
  localparam int            CW       = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic [AW-1:0] LAST_PIX = AW'(HRES * VRES - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(HRES - 1);

  frac_state_t   r_state;
  logic [W-1:0]  r_cx0, r_dx, r_dy, r_cur_cx, r_cur_cy;
  logic [15:0]   r_max_it;
  logic [CW-1:0] r_col;
  logic [AW-1:0] r_pix;
  logic [PW-1:0] r_rr_ptr, r_wb_ptr, r_wr_idx;
  logic [NE-1:0] r_tag_busy, r_cap_pend, r_slot_v;
  logic [AW-1:0] r_tag       [NE];
  logic [AW-1:0] r_slot_addr [NE];
  logic [15:0]   r_slot_data [NE];
  logic          r_wr_valid;
  logic [AW-1:0] r_wr_addr;
  logic [15:0]   r_wr_data;
  logic          r_done_tick;

  logic [NE-1:0] w_disp_req, w_disp_grant, w_wb_req, w_wb_grant, w_wr_clear, w_cap_set;
  logic [PW-1:0] w_disp_idx, w_wb_idx;
  logic          w_disp_ok, w_wb_ok, w_disp_fire, w_wr_accept, w_wb_load, w_drained;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
    return (int'(i) == NE - 1) ? '0 : i + 1'b1;
  endfunction

  // An engine holding an unwritten result is not re-used until that slot drains.
  assign w_disp_req  = eng_ready & ~r_slot_v & ~r_tag_busy;
  assign w_disp_fire = (r_state == ST_RUN) && w_disp_ok;
  assign w_wr_accept = r_wr_valid && wr_ready;
  assign w_wr_clear  = w_wr_accept ? (NE'(1) << r_wr_idx) : '0;
  assign w_wb_req    = r_slot_v & ~w_wr_clear;
  assign w_wb_load   = (!r_wr_valid || w_wr_accept) && w_wb_ok;
  assign w_cap_set   = eng_done & r_tag_busy & ~r_cap_pend;
  assign w_drained   = (r_tag_busy == '0) && (r_cap_pend == '0) &&
                       (r_slot_v == '0) && !r_wr_valid;

  frac_rr_pick #(.N(NE), .PW(PW)) u_disp_pick (
    .req   (w_disp_req),
    .ptr   (r_rr_ptr),
    .grant (w_disp_grant),
    .idx   (w_disp_idx),
    .valid (w_disp_ok)
  );

  frac_rr_pick #(.N(NE), .PW(PW)) u_wb_pick (
    .req   (w_wb_req),
    .ptr   (r_wb_ptr),
    .grant (w_wb_grant),
    .idx   (w_wb_idx),
    .valid (w_wb_ok)
  );

  assign busy       = (r_state != ST_IDLE);
  assign done_tick  = r_done_tick;
  assign eng_cx     = r_cur_cx;
  assign eng_cy     = r_cur_cy;
  assign eng_max_it = r_max_it;
  assign eng_start  = w_disp_fire ? w_disp_grant : '0;
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cx0       <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_cur_cx    <= '0;
      r_cur_cy    <= '0;
      r_max_it    <= '0;
      r_col       <= '0;
      r_pix       <= '0;
      r_rr_ptr    <= '0;
      r_wb_ptr    <= '0;
      r_wr_idx    <= '0;
      r_tag_busy  <= '0;
      r_cap_pend  <= '0;
      r_slot_v    <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done_tick <= 1'b0;
      for (int k = 0; k < NE; k++) begin
        r_tag[k]       <= '0;
        r_slot_addr[k] <= '0;
        r_slot_data[k] <= '0;
      end
    end else begin
      r_done_tick <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cx0    <= cx0;
            r_dx     <= dx;
            r_dy     <= dy;
            r_max_it <= max_it;
            r_cur_cx <= cx0;
            r_cur_cy <= cy0;
            r_col    <= '0;
            r_pix    <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_disp_fire) begin
            r_tag[w_disp_idx] <= r_pix;
            r_rr_ptr          <= ptr_after(w_disp_idx);
            if (r_col == LAST_COL) begin
              r_col    <= '0;
              r_cur_cx <= r_cx0;
              r_cur_cy <= r_cur_cy + r_dy;
            end else begin
              r_col    <= r_col + 1'b1;
              r_cur_cx <= r_cur_cx + r_dx;
            end
            if (r_pix == LAST_PIX) r_state <= ST_DRAIN;
            else                   r_pix   <= r_pix + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_done_tick <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Engine iter is only valid the cycle after its done tick, hence cap_pend.
      for (int k = 0; k < NE; k++) begin
        if (w_cap_set[k]) r_cap_pend[k] <= 1'b1;
        if (r_cap_pend[k]) begin
          r_slot_data[k] <= eng_iter[16*k +: 16];
          r_slot_addr[k] <= r_tag[k];
          r_slot_v[k]    <= 1'b1;
          r_tag_busy[k]  <= 1'b0;
          r_cap_pend[k]  <= 1'b0;
        end
        if (w_disp_fire && w_disp_grant[k]) r_tag_busy[k] <= 1'b1;
        if (w_wr_clear[k]) r_slot_v[k] <= 1'b0;
      end

      if (w_wr_accept) r_wr_valid <= 1'b0;
      if (w_wb_load) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= r_slot_addr[w_wb_idx];
        r_wr_data  <= r_slot_data[w_wb_idx];
        r_wr_idx   <= w_wb_idx;
        r_wb_ptr   <= ptr_after(w_wb_idx);
      end
    end
  end

endmodule : frac_sched
`default_nettype wire

// File: tb/tb_frac_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_frac_sched
//  Brief   : Self-checking bench: behavioural engine array and frame-buffer
//            sink around frac_sched, compared against a per-pixel model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_frac_sched;

  localparam int W = 32, NE = 4, HRES = 4, VRES = 2, AW = 4, NPIX = HRES * VRES;

  logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0]      cx0 = '0, cy0 = '0, dx = '0, dy = '0;
  logic [15:0]       max_it = '0;
  logic              busy, done_tick, wr_valid;
  logic [W-1:0]      eng_cx, eng_cy;
  logic [15:0]       eng_max_it, wr_data;
  logic [NE-1:0]     eng_start;
  logic [NE-1:0]     eng_ready = '1, eng_done = '0;
  logic [NE*16-1:0]  eng_iter = '0;
  logic [AW-1:0]     wr_addr;
  logic              wr_ready = 1'b1;

  frac_sched #(.W(W), .M(4), .NE(NE), .HRES(HRES), .VRES(VRES), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .cx0(cx0), .cy0(cy0), .dx(dx), .dy(dy),
    .max_it(max_it), .busy(busy), .done_tick(done_tick), .eng_cx(eng_cx), .eng_cy(eng_cy),
    .eng_max_it(eng_max_it), .eng_start(eng_start), .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_iter(eng_iter), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit rnd_mode = 1'b0;
  int sink_mode = 0;
  int viol, n_wr, n_done;
  int          wr_cnt [NPIX];
  logic [15:0] wr_dat [NPIX];
  logic [W-1:0] d_cx[$], d_cy[$];
  logic [15:0]  d_mi[$];
  int           d_k[$];
  int          e_cnt [NE], e_idle [NE];
  bit          e_busy [NE], e_post [NE];
  logic [15:0] e_res [NE];

  logic [NE-1:0] s_start;
  logic [W-1:0]  s_cx, s_cy, p_wa_w;
  logic [15:0]   s_mi, s_wd, p_wd;
  logic [AW-1:0] s_wa, p_wa;
  logic          s_wv, s_wr, s_done, s_rst, p_hold = 1'b0;

  // Pseudo-engine result: any deterministic function of the c it was handed.
  function automatic logic [15:0] eng_result(input logic [31:0] cx, input logic [31:0] cy,
                                             input logic [15:0] mi);
    logic [31:0] t;
    t = cx ^ (cx >> 13) ^ (cy * 32'd7) ^ (cy >> 19);
    return t[15:0] ^ t[31:16] ^ mi;
  endfunction

  function automatic int frame_errs(input logic [31:0] c0, input logic [31:0] y0,
                                    input logic [31:0] ddx, input logic [31:0] ddy,
                                    input logic [15:0] mi);
    int e = 0;
    for (int p = 0; p < NPIX; p++) begin
      logic [31:0] cx, cy;
      cx = c0 + 32'(p % HRES) * ddx;
      cy = y0 + 32'(p / HRES) * ddy;
      if (wr_cnt[p] != 1 || wr_dat[p] !== eng_result(cx, cy, mi)) e++;
    end
    return e;
  endfunction

  // Engine array and frame-buffer sink, sampled at the edge, driven 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      s_start = eng_start; s_cx = eng_cx; s_cy = eng_cy; s_mi = eng_max_it;
      s_wv = wr_valid; s_wr = wr_ready; s_wa = wr_addr; s_wd = wr_data;
      s_done = done_tick; s_rst = reset;
      #1;
      if (s_rst || reset) begin
        for (int k = 0; k < NE; k++) begin
          eng_ready[k] = 1'b1; eng_done[k] = 1'b0;
          e_busy[k] = 1'b0; e_post[k] = 1'b0; e_idle[k] = 0;
        end
        p_hold = 1'b0;
      end else begin
        if (s_done) n_done++;
        if ((s_start & (s_start - 1'b1)) != '0) viol++;
        if (p_hold && !(s_wv && s_wa == p_wa && s_wd == p_wd)) viol++;
        if (s_wv && s_wr) begin
          if (int'(s_wa) >= NPIX) viol++;
          else begin
            wr_cnt[int'(s_wa)]++;
            wr_dat[int'(s_wa)] = s_wd;
          end
          n_wr++;
        end
        p_hold = s_wv && !s_wr; p_wa = s_wa; p_wd = s_wd;
        for (int k = 0; k < NE; k++) begin
          eng_done[k] = 1'b0;
          if (s_start[k]) begin
            if (!eng_ready[k]) viol++;
            d_k.push_back(k); d_cx.push_back(s_cx); d_cy.push_back(s_cy); d_mi.push_back(s_mi);
            e_busy[k] = 1'b1; e_post[k] = 1'b0; e_idle[k] = 0;
            e_cnt[k] = rnd_mode ? int'($urandom_range(0, 6)) : 3;
            e_res[k] = eng_result(s_cx, s_cy, s_mi);
            eng_ready[k] = 1'b0;
          end else if (e_post[k]) begin
            e_post[k] = 1'b0;
            eng_iter[16*k +: 16] = e_res[k];
            eng_ready[k] = 1'b1;
          end else if (e_busy[k]) begin
            if (e_cnt[k] == 0) begin
              eng_done[k] = 1'b1;
              eng_iter[16*k +: 16] = 16'($urandom);
              e_busy[k] = 1'b0; e_post[k] = 1'b1;
            end else e_cnt[k]--;
          end else begin
            e_idle[k]++;
            if (rnd_mode) begin
              eng_ready[k] = ($urandom % 4) != 0;
              if (e_idle[k] > 3 && ($urandom % 16) == 0) begin
                eng_done[k] = 1'b1;
                eng_iter[16*k +: 16] = 16'($urandom);
              end
            end else eng_ready[k] = 1'b1;
          end
        end
        case (sink_mode)
          0:       wr_ready = 1'b1;
          1:       wr_ready = ($urandom % 3) != 0;
          default: wr_ready = 1'b0;
        endcase
      end
    end
  end

  task automatic clear_sb();
    n_wr = 0; n_done = 0; viol = 0;
    for (int p = 0; p < NPIX; p++) begin wr_cnt[p] = 0; wr_dat[p] = '0; end
    d_k.delete(); d_cx.delete(); d_cy.delete(); d_mi.delete();
  endtask

  task automatic begin_frame(input logic [31:0] c0, input logic [31:0] y0,
                             input logic [31:0] ddx, input logic [31:0] ddy,
                             input logic [15:0] mi);
    @(negedge clk);
    cx0 = c0; cy0 = y0; dx = ddx; dy = ddy; max_it = mi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(output bit timeout);
    int n = 0;
    while (n_done == 0 && n < 4000) begin @(negedge clk); n++; end
    timeout = (n_done == 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done_tick, wr_valid, eng_start, eng_cx, eng_cy, eng_max_it, wr_addr, wr_data} !== '0)
      $display("FAIL reset_held: outputs=%h required=0",
               {busy, done_tick, wr_valid, eng_start, eng_cx, eng_cy, eng_max_it, wr_addr, wr_data});
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, wr_valid, eng_start} !== '0)
      $display("FAIL reset_idle: busy/wr_valid/eng_start=%b required=0", {busy, wr_valid, eng_start});
    else n_pass++;
  endtask

  task automatic test_dispatch_order();
    bit to;
    rnd_mode = 1'b0; sink_mode = 0; clear_sb();
    begin_frame(32'h0, 32'h0, 32'h1000_0000, 32'h0, 16'd100);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL order_busy: busy=%b required=1", busy); else n_pass++;
    wait_frame(to);
    n_chk++;
    if (to || d_k.size() != NPIX) $display("FAIL order_count: dispatches=%0d required=%0d", d_k.size(), NPIX);
    else begin
      n_pass++;
      for (int i = 0; i < NE; i++) begin
        n_chk++;
        if (d_k[i] != i) $display("FAIL order_engine: start %0d went to engine %0d required %0d", i, d_k[i], i);
        else n_pass++;
        n_chk++;
        if (d_cx[i] !== 32'h1000_0000 * i) $display("FAIL order_cx: start %0d eng_cx=%h required %h", i, d_cx[i], 32'h1000_0000 * i);
        else n_pass++;
      end
    end
    n_chk++;
    if (frame_errs(32'h0, 32'h0, 32'h1000_0000, 32'h0, 16'd100) != 0 || n_wr != NPIX || n_done != 1 || viol != 0)
      $display("FAIL order_frame: bad_pixels=%0d writes=%0d done=%0d violations=%0d required 0/%0d/1/0",
               frame_errs(32'h0, 32'h0, 32'h1000_0000, 32'h0, 16'd100), n_wr, n_done, viol, NPIX);
    else n_pass++;
  endtask

  task automatic test_cy_wrap();
    bit to;
    rnd_mode = 1'b0; sink_mode = 0; clear_sb();
    begin_frame(32'hF000_0000, 32'h7FFF_FFFF, 32'h0100_0000, 32'h1, 16'd7);
    wait_frame(to);
    n_chk++;
    if (to || d_cy.size() != NPIX) $display("FAIL wrap_count: dispatches=%0d required=%0d", d_cy.size(), NPIX);
    else begin
      n_pass++;
      n_chk++;
      if (d_cy[HRES] !== 32'h8000_0000) $display("FAIL wrap_row1: eng_cy=%h required 80000000", d_cy[HRES]);
      else n_pass++;
      for (int p = 0; p < NPIX; p++) begin
        n_chk++;
        if (d_cx[p] !== 32'hF000_0000 + 32'(p % HRES) * 32'h0100_0000 ||
            d_cy[p] !== 32'h7FFF_FFFF + 32'(p / HRES) || d_mi[p] !== 16'd7)
          $display("FAIL wrap_c: pixel %0d cx=%h cy=%h max_it=%0d", p, d_cx[p], d_cy[p], d_mi[p]);
        else n_pass++;
      end
    end
    n_chk++;
    if (frame_errs(32'hF000_0000, 32'h7FFF_FFFF, 32'h0100_0000, 32'h1, 16'd7) != 0 || n_done != 1 || viol != 0)
      $display("FAIL wrap_frame: writes=%0d done=%0d violations=%0d", n_wr, n_done, viol);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    int n = 0, d100;
    rnd_mode = 1'b0; sink_mode = 2; clear_sb();
    begin_frame(32'h0123_4567, 32'h89AB_CDEF, 32'h0010_0000, 32'hFF00_0000, 16'd33);
    while (!wr_valid && n < 200) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    d100 = d_k.size();
    repeat (100) @(negedge clk);
    n_chk++;
    if (d_k.size() != NE || d100 != NE)
      $display("FAIL stall_dispatch: dispatches=%0d/%0d required %0d", d100, d_k.size(), NE);
    else n_pass++;
    n_chk++;
    if (wr_valid !== 1'b1 || viol != 0) $display("FAIL stall_hold: wr_valid=%b violations=%0d required 1/0", wr_valid, viol);
    else n_pass++;
    sink_mode = 0;
    wait_frame(to);
    n_chk++;
    if (to || frame_errs(32'h0123_4567, 32'h89AB_CDEF, 32'h0010_0000, 32'hFF00_0000, 16'd33) != 0 ||
        n_wr != NPIX || n_done != 1 || viol != 0)
      $display("FAIL stall_resume: writes=%0d done=%0d violations=%0d required %0d/1/0", n_wr, n_done, viol, NPIX);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    bit to;
    rnd_mode = 1'b0; sink_mode = 0; clear_sb();
    begin_frame(32'h0200_0000, 32'h0300_0000, 32'h0040_0000, 32'h0080_0000, 16'd12);
    @(negedge clk);
    cx0 = 32'h5555_5555; dx = 32'h1; max_it = 16'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame(to);
    n_chk++;
    if (to || d_k.size() != NPIX || n_wr != NPIX || n_done != 1)
      $display("FAIL ignore_count: dispatches=%0d writes=%0d done=%0d required %0d/%0d/1", d_k.size(), n_wr, n_done, NPIX, NPIX);
    else n_pass++;
    n_chk++;
    if (frame_errs(32'h0200_0000, 32'h0300_0000, 32'h0040_0000, 32'h0080_0000, 16'd12) != 0 || viol != 0)
      $display("FAIL ignore_data: bad_pixels=%0d violations=%0d required 0/0",
               frame_errs(32'h0200_0000, 32'h0300_0000, 32'h0040_0000, 32'h0080_0000, 16'd12), viol);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    rnd_mode = 1'b0; sink_mode = 0; clear_sb();
    begin_frame(32'h1111_1111, 32'h2222_2222, 32'h3, 32'h4, 16'd50);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, wr_valid, eng_start, eng_cx, eng_cy, eng_max_it} !== '0)
      $display("FAIL midreset_outputs: value=%h required 0", {busy, wr_valid, eng_start, eng_cx, eng_cy, eng_max_it});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_sb();
    begin_frame(32'hABCD_0000, 32'h0000_1234, 32'h0002_0000, 32'hFFFF_0000, 16'd9);
    wait_frame(to);
    n_chk++;
    if (to || frame_errs(32'hABCD_0000, 32'h0000_1234, 32'h0002_0000, 32'hFFFF_0000, 16'd9) != 0 ||
        n_wr != NPIX || n_done != 1 || viol != 0)
      $display("FAIL midreset_frame: writes=%0d done=%0d violations=%0d required %0d/1/0", n_wr, n_done, viol, NPIX);
    else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] c0, y0, ddx, ddy;
    logic [15:0] mi;
    rnd_mode = 1'b1; sink_mode = 1;
    for (int f = 0; f < 6; f++) begin
      clear_sb();
      c0 = $urandom; y0 = $urandom; ddx = $urandom; ddy = $urandom; mi = 16'($urandom);
      begin_frame(c0, y0, ddx, ddy, mi);
      wait_frame(to);
      n_chk++;
      if (to || frame_errs(c0, y0, ddx, ddy, mi) != 0 || n_wr != NPIX || n_done != 1 || viol != 0)
        $display("FAIL random_frame%0d: bad_pixels=%0d writes=%0d done=%0d violations=%0d required 0/%0d/1/0",
                 f, frame_errs(c0, y0, ddx, ddy, mi), n_wr, n_done, viol, NPIX);
      else n_pass++;
    end
    rnd_mode = 1'b0; sink_mode = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    clear_sb();
    test_reset();
    test_dispatch_order();
    test_cy_wrap();
    test_backpressure();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_frac_sched
`default_nettype wire
